// File: rtl/cache_writeback_unit_pkg.sv
// Shared types for the cache line writeback path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cache_writeback_unit_pkg;

  // One word of the cache data store / memory write channel.
  typedef logic [31:0] data_word_t;

  // Line drain sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } writeback_fsm_t;

  // Byte offset bits inside one 32-bit word.
  localparam int unsigned WORD_OFFSET_BITS = 2;

  // Skid capacity needed to absorb one-cycle read latency at full rate.
  localparam int unsigned WB_BUF_DEPTH = 2;

endpackage

// File: rtl/cache_writeback_unit_if.sv
// Bundle of controller, data-store and memory-channel signals of the writeback unit.
// Latency: n/a (wiring only).
// Backpressure: mem_ready_i is the only stall input; slave = unit, master = surrounding logic.
interface cache_writeback_unit_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int BANK_ADDRESS = 4,
  parameter int PADDR_WIDTH  = 32
);
  import cache_writeback_unit_pkg::*;

  // Controller side
  logic                    writeback_i;
  logic [ADDR_WIDTH-1:0]   writeback_index_i;
  logic [PADDR_WIDTH-1:0]  writeback_address_i;
  logic                    busy_o;
  logic                    done_o;

  // Data store side
  logic                    cache_read_o;
  logic [BANK_ADDRESS-1:0] cache_read_bank_o;
  logic [ADDR_WIDTH-1:0]   cache_read_address_o;
  data_word_t              cache_read_data_i;

  // Memory write channel
  logic                    mem_valid_o;
  logic [PADDR_WIDTH-1:0]  mem_address_o;
  data_word_t              mem_data_o;
  logic                    mem_last_o;
  logic                    mem_ready_i;

  modport slave (
    input  writeback_i, writeback_index_i, writeback_address_i,
    input  cache_read_data_i, mem_ready_i,
    output busy_o, done_o,
    output cache_read_o, cache_read_bank_o, cache_read_address_o,
    output mem_valid_o, mem_address_o, mem_data_o, mem_last_o
  );

  modport master (
    output writeback_i, writeback_index_i, writeback_address_i,
    output cache_read_data_i, mem_ready_i,
    input  busy_o, done_o,
    input  cache_read_o, cache_read_bank_o, cache_read_address_o,
    input  mem_valid_o, mem_address_o, mem_data_o, mem_last_o
  );

endinterface

// File: rtl/cache_writeback_unit_buffer.sv
// Two-entry FIFO holding words read from the data store until memory accepts them.
// Latency: pushed word is visible at head the cycle after the push edge.
// Backpressure: no internal stall; the reader throttles issue so push never hits a full buffer.
module writeback_buffer
  import cache_writeback_unit_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  data_word_t push_data_i,
  input  logic       pop_i,
  output data_word_t head_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [1:0] count_o
);

  data_word_t mem_q [WB_BUF_DEPTH];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;

  // Storage, pointers and occupancy; storage is cleared so the head reads 0 out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign count_o = count_q;

endmodule

// File: rtl/cache_writeback_unit.sv
// Drains one cache line, word by word in bank order, from the data store to the memory write channel.
// Latency: start at edge T0 -> first read in T1 -> first mem_valid_o in T3; then 1 word/cycle.
// Backpressure: mem_ready_i low holds the head word stable and throttles reads to two outstanding words.
module cache_writeback_unit
  import cache_writeback_unit_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int BANK_ADDRESS = 4,
  parameter int PADDR_WIDTH  = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  cache_writeback_unit_if.slave  wb
);

  // Clears the in-line byte offset so addresses start at the line boundary.
  localparam logic [PADDR_WIDTH-1:0] LINE_MASK =
    ~((PADDR_WIDTH'(1) << (BANK_ADDRESS + WORD_OFFSET_BITS)) - PADDR_WIDTH'(1));
  localparam logic [BANK_ADDRESS:0]   ISSUE_ONE = 1;
  localparam logic [BANK_ADDRESS-1:0] SEND_ONE  = 1;

  writeback_fsm_t           state_q;
  logic [ADDR_WIDTH-1:0]    index_q;
  logic [PADDR_WIDTH-1:0]   base_q;
  logic [BANK_ADDRESS:0]    issue_q;     // reads issued; MSB set once the whole line is requested
  logic [BANK_ADDRESS-1:0]  send_q;      // words accepted by memory
  logic                     inflight_q;  // a read was issued last cycle, data arrives now

  data_word_t buf_head;
  logic       buf_full;
  logic       buf_empty;
  logic [1:0] buf_count;
  logic       buf_push;
  logic       pop;
  logic       start;
  logic       send_last;
  logic       rd_issue;
  logic [2:0] occ_after_pop;

  assign start     = wb.writeback_i && (state_q != ACTIVE);
  assign pop       = !buf_empty && wb.mem_ready_i;
  assign send_last = (send_q == '1);

  // Words that will be held once this cycle's pop and the in-flight read settle;
  // keeping this below two means the read issued now always finds a free slot.
  assign occ_after_pop = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_issue      = (state_q == ACTIVE) && !issue_q[BANK_ADDRESS] && (occ_after_pop < 3'd2);

  // Full-with-no-pop can not coincide with returning data; the guard only documents that.
  assign buf_push = inflight_q && (!buf_full || pop);

  // Sequencer: start latching, read issue count, send count and line completion.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      index_q    <= '0;
      base_q     <= '0;
      issue_q    <= '0;
      send_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_issue;
      if (start) begin
        index_q <= wb.writeback_index_i;
        base_q  <= wb.writeback_address_i & LINE_MASK;
      end
      unique case (state_q)
        IDLE: begin
          issue_q <= '0;
          send_q  <= '0;
          if (start) state_q <= ACTIVE;
        end
        ACTIVE: begin
          if (rd_issue) issue_q <= issue_q + ISSUE_ONE;
          if (pop) begin
            send_q <= send_q + SEND_ONE;
            if (send_last) state_q <= DONE;
          end
        end
        DONE: begin
          issue_q <= '0;
          send_q  <= '0;
          state_q <= start ? ACTIVE : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  writeback_buffer u_buffer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (buf_push),
    .push_data_i (wb.cache_read_data_i),
    .pop_i       (pop),
    .head_o      (buf_head),
    .full_o      (buf_full),
    .empty_o     (buf_empty),
    .count_o     (buf_count)
  );

  assign wb.busy_o               = (state_q == ACTIVE);
  assign wb.done_o               = (state_q == DONE);
  assign wb.cache_read_o         = rd_issue;
  assign wb.cache_read_bank_o    = issue_q[BANK_ADDRESS-1:0];
  assign wb.cache_read_address_o = index_q;
  assign wb.mem_valid_o          = !buf_empty;
  assign wb.mem_data_o           = buf_head;
  assign wb.mem_address_o        = base_q + (PADDR_WIDTH'(send_q) << WORD_OFFSET_BITS);
  assign wb.mem_last_o           = !buf_empty && send_last;

endmodule

// File: tb/tb_cache_writeback_unit.sv
// Scoreboard bench for cache_writeback_unit with a 4-word line.
// Latency: n/a.
// Backpressure: mem_ready_i is driven fixed, windowed or random.
module tb_cache_writeback_unit;
  import cache_writeback_unit_pkg::*;

  localparam int AW = 32;
  localparam int BA = 2;
  localparam int PW = 32;
  localparam int NW = 1 << BA;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_writeback_unit_if #(.ADDR_WIDTH(AW), .BANK_ADDRESS(BA), .PADDR_WIDTH(PW)) bus ();

  cache_writeback_unit #(.ADDR_WIDTH(AW), .BANK_ADDRESS(BA), .PADDR_WIDTH(PW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb    (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } exp_word_t;

  typedef struct {
    logic [31:0] idx;
    int          bank;
  } exp_read_t;

  exp_word_t exp_q[$];
  exp_read_t rd_q[$];
  int rd_cyc[$];
  int vl_cyc[$];
  logic [31:0] hs_addr[$];

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int n_acc = 0;
  int n_done = 0;
  int done_cyc = 0;
  int hs_cnt = 0;
  int stall_from = 1;
  int stall_to = 0;
  bit ready_rand = 1'b0;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Contents of the data store: distinct per index and bank.
  function automatic data_word_t store_word(input logic [31:0] idx, input int bank);
    return (idx * 32'h9E3779B1) ^ (32'(bank) << 28) ^ 32'h00C0FFEE;
  endfunction

  // Data store responder: data appears one cycle after the read strobe.
  initial begin
    bit         p;
    data_word_t v;
    bus.cache_read_data_i = '0;
    forever begin
      @(negedge clk);
      p = bus.cache_read_o;
      v = store_word(bus.cache_read_address_o, int'(bus.cache_read_bank_o));
      @(posedge clk);
      #1;
      bus.cache_read_data_i = p ? v : data_word_t'($urandom);
    end
  end

  // Memory ready driver.
  initial begin
    bus.mem_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_rand) bus.mem_ready_i = 1'($urandom_range(0, 1));
      else            bus.mem_ready_i = !(cyc >= stall_from && cyc <= stall_to);
    end
  end

  // Monitor + reference model: a transfer is either in progress or not; a request while
  // not in progress starts a new line whose words are the aligned line in order.
  initial begin
    bit          prev_stall;
    logic [31:0] p_addr, p_data;
    logic        p_last;
    bit          last_hs;
    exp_word_t   e;
    exp_read_t   r;
    logic [31:0] base;
    prev_stall = 1'b0;
    p_addr = '0; p_data = '0; p_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        rd_q.delete();
        m_busy = 1'b0;
        m_done = 1'b0;
        prev_stall = 1'b0;
      end else begin
        chk("busy", bus.busy_o, m_busy);
        chk("done", bus.done_o, m_done);
        if (bus.done_o) begin
          n_done++;
          done_cyc = cyc;
        end
        if (bus.cache_read_o) begin
          rd_cyc.push_back(cyc);
          if (rd_q.size() == 0) chk("unexpected_read", 1, 0);
          else begin
            r = rd_q.pop_front();
            chk("read_index", bus.cache_read_address_o, r.idx);
            chk("read_bank", 32'(bus.cache_read_bank_o), r.bank);
          end
        end
        if (bus.mem_valid_o) vl_cyc.push_back(cyc);
        if (prev_stall) begin
          chk("stall_valid", bus.mem_valid_o, 1);
          chk("stall_addr", bus.mem_address_o, p_addr);
          chk("stall_data", bus.mem_data_o, p_data);
          chk("stall_last", bus.mem_last_o, p_last);
        end
        prev_stall = bus.mem_valid_o && !bus.mem_ready_i;
        p_addr = bus.mem_address_o;
        p_data = bus.mem_data_o;
        p_last = bus.mem_last_o;
        last_hs = 1'b0;
        if (bus.mem_valid_o && bus.mem_ready_i) begin
          hs_cnt++;
          hs_addr.push_back(bus.mem_address_o);
          if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("word_addr", bus.mem_address_o, e.addr);
            chk("word_data", bus.mem_data_o, e.data);
            chk("word_last", bus.mem_last_o, e.last);
            last_hs = e.last;
          end
        end
        if (!m_busy && bus.writeback_i === 1'b1) begin
          base = (bus.writeback_address_i / (4 * NW)) * (4 * NW);
          for (int k = 0; k < NW; k++) begin
            exp_q.push_back('{base + 32'(4 * k), store_word(bus.writeback_index_i, k), k == NW - 1});
            rd_q.push_back('{bus.writeback_index_i, k});
          end
          acc_cyc = cyc;
          n_acc++;
        end
        m_done = last_hs;
        m_busy = m_busy ? !last_hs : (bus.writeback_i === 1'b1);
      end
    end
  end

  task automatic outputs_zero(input string tag);
    chk({tag, "_busy"}, bus.busy_o, 0);
    chk({tag, "_done"}, bus.done_o, 0);
    chk({tag, "_rd"}, bus.cache_read_o, 0);
    chk({tag, "_bank"}, 32'(bus.cache_read_bank_o), 0);
    chk({tag, "_rdaddr"}, bus.cache_read_address_o, 0);
    chk({tag, "_valid"}, bus.mem_valid_o, 0);
    chk({tag, "_maddr"}, bus.mem_address_o, 0);
    chk({tag, "_mdata"}, bus.mem_data_o, 0);
    chk({tag, "_last"}, bus.mem_last_o, 0);
  endtask

  task automatic start_xfer(input logic [31:0] idx, input logic [31:0] addr);
    @(posedge clk); #1;
    bus.writeback_i = 1'b1;
    bus.writeback_index_i = idx;
    bus.writeback_address_i = addr;
    @(posedge clk); #1;
    bus.writeback_i = 1'b0;
    bus.writeback_index_i = $urandom;
    bus.writeback_address_i = $urandom;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((m_busy || m_done || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("timeout", 1, 0);
    @(negedge clk);
  endtask

  initial begin
    int n0, h0, d0, dm, n;
    bus.writeback_i = 1'b0;
    bus.writeback_index_i = '0;
    bus.writeback_address_i = '0;

    // 1: asynchronous reset between edges
    #2 rst = 1'b1;
    #1 outputs_zero("rst_async");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 2: nominal transfer, ready always high
    rd_cyc.delete(); vl_cyc.delete();
    start_xfer(32'h5, 32'h8000_0040);
    wait_idle(100);
    chk("t2_nreads", rd_cyc.size(), 4);
    for (int k = 0; k < 4 && k < rd_cyc.size(); k++) chk("t2_read_cyc", rd_cyc[k], acc_cyc + 1 + k);
    chk("t2_nvalid", vl_cyc.size(), 4);
    for (int k = 0; k < 4 && k < vl_cyc.size(); k++) chk("t2_valid_cyc", vl_cyc[k], acc_cyc + 3 + k);
    chk("t2_done_cyc", done_cyc, acc_cyc + 7);

    // 3: ready low during T3..T7
    rd_cyc.delete();
    d0 = n_done;
    start_xfer(32'h5, 32'h8000_0040);
    stall_from = acc_cyc + 3;
    stall_to = acc_cyc + 7;
    n = 0;
    while (cyc != acc_cyc + 5 && n < 50) begin @(negedge clk); n++; end
    chk("t3_hold_valid", bus.mem_valid_o, 1);
    chk("t3_hold_addr", bus.mem_address_o, 32'h8000_0040);
    chk("t3_hold_data", bus.mem_data_o, store_word(32'h5, 0));
    wait_idle(100);
    n = 0;
    foreach (rd_cyc[k]) if (rd_cyc[k] <= acc_cyc + 7) n++;
    chk("t3_reads_in_stall", n, 2);
    chk("t3_done_once", n_done - d0, 1);
    stall_from = 1; stall_to = 0;

    // 4: unaligned start address
    hs_addr.delete();
    start_xfer(32'h9, 32'h8000_0047);
    wait_idle(100);
    chk("t4_first_addr", hs_addr.size() > 0 ? hs_addr[0] : 32'hx, 32'h8000_0040);
    chk("t4_last_addr", hs_addr.size() > 3 ? hs_addr[3] : 32'hx, 32'h8000_004C);

    // 5: dropped mid-transfer request, then back-to-back start in DONE
    n0 = n_acc; h0 = hs_cnt;
    start_xfer(32'h5, 32'h8000_0040);
    @(posedge clk); #1;
    bus.writeback_i = 1'b1;
    bus.writeback_index_i = 32'h77;
    bus.writeback_address_i = 32'h0000_1000;
    @(posedge clk); #1;
    bus.writeback_i = 1'b0;
    n = 0;
    while (bus.done_o !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    dm = cyc;
    rd_cyc.delete();
    bus.writeback_i = 1'b1;
    bus.writeback_index_i = 32'h6;
    bus.writeback_address_i = 32'h8000_00C0;
    @(posedge clk); #1;
    bus.writeback_i = 1'b0;
    wait_idle(100);
    chk("t5_accepts", n_acc - n0, 2);
    chk("t5_words", hs_cnt - h0, 8);
    chk("t5_b2b_acc_cyc", acc_cyc, dm);
    chk("t5_b2b_first_read", rd_cyc.size() > 0 ? rd_cyc[0] : -1, dm + 1);

    // 6: reset after the second handshake
    h0 = hs_cnt;
    start_xfer(32'h3, 32'h8000_0100);
    n = 0;
    while (hs_cnt < h0 + 2 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #3;
    rst = 1'b1;
    d0 = n_done;
    #1 outputs_zero("rst_mid");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_no_done", n_done - d0, 0);
    h0 = hs_cnt;
    start_xfer(32'h4, 32'h8000_0200);
    wait_idle(100);
    chk("t6_after_words", hs_cnt - h0, 4);

    // Random traffic and random backpressure
    ready_rand = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      @(posedge clk); #1;
      bus.writeback_i = ($urandom_range(0, 5) == 0);
      bus.writeback_index_i = $urandom;
      bus.writeback_address_i = $urandom;
    end
    @(posedge clk); #1;
    bus.writeback_i = 1'b0;
    wait_idle(500);
    chk("end_words_left", exp_q.size(), 0);
    chk("end_reads_left", rd_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
